// File: rtl/pulse_avg_sequencer.sv
// pulse_avg_sequencer: run controller between the AXI wrapper sample stream and
// pulse_avg_core. Latches the averaging config at start, clears the averager,
// aligns to a packet boundary, gates num_avg pulses of pulse_size samples into
// the core, waits for the averaged pulse to leave, and repeats per run limit.
module pulse_avg_sequencer #(
  parameter int unsigned MAX_PULSE_SIZE = 8192,
  parameter int unsigned RUN_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      cfg_pulse_size,
  input  logic [31:0]      cfg_num_avg,
  input  logic [RUN_W-1:0] cfg_num_runs,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      s_tdata,
  input  logic             s_tlast,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [31:0]      core_tdata,
  output logic             core_tlast,
  output logic             core_tvalid,
  input  logic             core_tready,
  output logic             core_clear,
  output logic [31:0]      core_pulse_size,
  output logic [31:0]      core_num_avg,
  input  logic             avg_tvalid,
  input  logic             avg_tready,
  input  logic             avg_tlast,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             err_len,
  output logic [RUN_W-1:0] run_count,
  output logic [31:0]      pulse_count
);

  // Sample counter only needs to index up to MAX_PULSE_SIZE-1.
  localparam int unsigned CNT_W = $clog2(MAX_PULSE_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ALIGN,
    S_PASS,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        core_pulse_size_q, core_pulse_size_d;
  logic [31:0]        core_num_avg_q, core_num_avg_d;
  logic [RUN_W-1:0]   run_limit_q, run_limit_d;
  logic [RUN_W-1:0]   run_count_q, run_count_d;
  logic [31:0]        pulse_count_q, pulse_count_d;
  logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic               core_clear_q, core_clear_d;
  logic               done_q, done_d;
  logic               err_cfg_q, err_cfg_d;
  logic               err_len_q, err_len_d;
  logic               busy_q, busy_d;

  logic               abort_hit;
  logic               cfg_ok;
  logic               gen_last;
  logic               core_hs;
  logic               align_hs;
  logic               avg_hs;
  logic [RUN_W-1:0]   run_count_inc;
  logic [31:0]        pulse_count_inc;

  // Decode of the run-control conditions shared by stream and FSM logic.
  always_comb begin
    abort_hit       = abort && (state_q != S_IDLE);
    cfg_ok          = (cfg_pulse_size != 32'd0) &&
                      (cfg_pulse_size <= 32'(MAX_PULSE_SIZE)) &&
                      (cfg_num_avg != 32'd0);
    gen_last        = (samp_cnt_q == CNT_W'(core_pulse_size_q - 32'd1));
    avg_hs          = avg_tvalid && avg_tready && avg_tlast;
    run_count_inc   = (run_count_q == {RUN_W{1'b1}}) ? run_count_q
                                                     : run_count_q + RUN_W'(1);
    pulse_count_inc = pulse_count_q + 32'd1;
  end

  // Zero-latency stream gating: discard in ALIGN, pass through in PASS,
  // and drop both valid and ready in the cycle an abort is taken.
  always_comb begin
    s_tready    = 1'b0;
    core_tvalid = 1'b0;
    core_tlast  = 1'b0;
    if (!abort_hit) begin
      if (state_q == S_ALIGN) begin
        s_tready = 1'b1;
      end else if (state_q == S_PASS) begin
        s_tready    = core_tready;
        core_tvalid = s_tvalid;
        core_tlast  = gen_last;
      end
    end
  end

  assign core_tdata = s_tdata;

  // Handshakes observed on the gated stream.
  always_comb begin
    core_hs  = core_tvalid && core_tready;
    align_hs = (state_q == S_ALIGN) && s_tvalid && s_tready && s_tlast;
  end

  // Next-state, counter and pulse-output logic.
  always_comb begin
    state_d           = state_q;
    core_pulse_size_d = core_pulse_size_q;
    core_num_avg_d    = core_num_avg_q;
    run_limit_d       = run_limit_q;
    run_count_d       = run_count_q;
    pulse_count_d     = pulse_count_q;
    samp_cnt_d        = samp_cnt_q;
    err_cfg_d         = 1'b0;
    err_len_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            core_pulse_size_d = cfg_pulse_size;
            core_num_avg_d    = cfg_num_avg;
            run_limit_d       = cfg_num_runs;
            run_count_d       = '0;
            state_d           = S_CLEAR;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end

      S_CLEAR: begin
        pulse_count_d = '0;
        samp_cnt_d    = '0;
        state_d       = S_ALIGN;
      end

      S_ALIGN: begin
        if (align_hs) begin
          state_d = S_PASS;
        end
      end

      S_PASS: begin
        if (core_hs) begin
          // Framing comes from the counter; input tlast is only cross-checked.
          if (s_tlast != gen_last) begin
            err_len_d = 1'b1;
          end
          if (gen_last) begin
            samp_cnt_d    = '0;
            pulse_count_d = pulse_count_inc;
            if (pulse_count_inc == core_num_avg_q) begin
              state_d = S_DRAIN;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + CNT_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if (avg_hs) begin
          run_count_d = run_count_inc;
          if ((run_limit_q != '0) && (run_count_inc == run_limit_q)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides the transition but leaves counters as computed.
    if (abort_hit) begin
      state_d = S_IDLE;
    end

    core_clear_d = (state_d == S_CLEAR);
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // State, config and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      core_pulse_size_q <= 32'(MAX_PULSE_SIZE);
      core_num_avg_q    <= 32'd1;
      run_limit_q       <= '0;
      run_count_q       <= '0;
      pulse_count_q     <= '0;
      samp_cnt_q        <= '0;
      core_clear_q      <= 1'b0;
      done_q            <= 1'b0;
      err_cfg_q         <= 1'b0;
      err_len_q         <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      core_pulse_size_q <= core_pulse_size_d;
      core_num_avg_q    <= core_num_avg_d;
      run_limit_q       <= run_limit_d;
      run_count_q       <= run_count_d;
      pulse_count_q     <= pulse_count_d;
      samp_cnt_q        <= samp_cnt_d;
      core_clear_q      <= core_clear_d;
      done_q            <= done_d;
      err_cfg_q         <= err_cfg_d;
      err_len_q         <= err_len_d;
      busy_q            <= busy_d;
    end
  end

  // The abort clear must reach the core in the abort cycle itself, so it is
  // merged with the registered CLEAR-state pulse.
  assign core_clear      = core_clear_q || abort_hit;
  assign core_pulse_size = core_pulse_size_q;
  assign core_num_avg    = core_num_avg_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_cfg         = err_cfg_q;
  assign err_len         = err_len_q;
  assign run_count       = run_count_q;
  assign pulse_count     = pulse_count_q;

endmodule

// File: tb/tb_pulse_avg_sequencer.sv
// Self-checking bench for pulse_avg_sequencer: randomized runs checked against
// an expected-beat queue built from the framing rules and run bookkeeping.
module tb_pulse_avg_sequencer;

  localparam int unsigned MAXP  = 8192;
  localparam int unsigned RUN_W = 16;

  logic             clk;
  logic             reset_n;
  logic [31:0]      cfg_pulse_size;
  logic [31:0]      cfg_num_avg;
  logic [RUN_W-1:0] cfg_num_runs;
  logic             start;
  logic             abort;
  logic [31:0]      s_tdata;
  logic             s_tlast;
  logic             s_tvalid;
  logic             s_tready;
  logic [31:0]      core_tdata;
  logic             core_tlast;
  logic             core_tvalid;
  logic             core_tready;
  logic             core_clear;
  logic [31:0]      core_pulse_size;
  logic [31:0]      core_num_avg;
  logic             avg_tvalid;
  logic             avg_tready;
  logic             avg_tlast;
  logic             busy;
  logic             done;
  logic             err_cfg;
  logic             err_len;
  logic [RUN_W-1:0] run_count;
  logic [31:0]      pulse_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned err_seen = 0;
  int unsigned exp_err  = 0;
  int unsigned clear_seen = 0;
  int unsigned done_seen  = 0;
  bit          bp_en  = 1'b0;
  bit          gap_en = 1'b0;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  pulse_avg_sequencer #(.MAX_PULSE_SIZE(MAXP), .RUN_W(RUN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_pulse_size(cfg_pulse_size), .cfg_num_avg(cfg_num_avg), .cfg_num_runs(cfg_num_runs),
    .start(start), .abort(abort),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .core_tdata(core_tdata), .core_tlast(core_tlast), .core_tvalid(core_tvalid),
    .core_tready(core_tready), .core_clear(core_clear),
    .core_pulse_size(core_pulse_size), .core_num_avg(core_num_avg),
    .avg_tvalid(avg_tvalid), .avg_tready(avg_tready), .avg_tlast(avg_tlast),
    .busy(busy), .done(done), .err_cfg(err_cfg), .err_len(err_len),
    .run_count(run_count), .pulse_count(pulse_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core backpressure source.
  initial begin
    core_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      core_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (core_tvalid) begin
        check("tready_track", 64'(s_tready), 64'(core_tready));
        if (core_tready) got_q.push_back({core_tlast, core_tdata});
      end
      if (err_len)    err_seen++;
      if (core_clear) clear_seen++;
      if (done)       done_seen++;
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    if (gap_en && ($urandom_range(0, 3) == 0)) begin
      @(posedge clk);
      #1;
    end
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge clk);
      ok = s_tready;
      if (!ok) @(posedge clk);
    end
    if (!ok) check("hs_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  // mode 0: correct tlast, 1: random tlast flips, 2: tlast one beat early.
  task automatic feed_run(input int unsigned p, input int unsigned nbeats, input int unsigned mode);
    int unsigned junk;
    logic [31:0] d;
    logic        gl;
    logic        sl;
    junk = $urandom_range(0, 2);
    for (int i = 0; i < int'(junk); i++) send_beat($urandom, 1'b0);
    send_beat($urandom, 1'b1);
    for (int i = 0; i < int'(nbeats); i++) begin
      d  = $urandom;
      gl = ((int'(p) == 1) || ((i % int'(p)) == int'(p) - 1));
      sl = gl;
      if (mode == 1 && $urandom_range(0, 3) == 0) sl = ~gl;
      if (mode == 2) sl = ((i % int'(p)) == int'(p) - 2);
      if (sl != gl) exp_err++;
      exp_q.push_back({gl, d});
      send_beat(d, sl);
    end
  endtask

  task automatic do_start(input int unsigned p, input int unsigned n, input int unsigned runs,
                          input bit ok, input bit with_abort);
    cfg_pulse_size = p;
    cfg_num_avg    = n;
    cfg_num_runs   = RUN_W'(runs);
    abort          = with_abort;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start          = 1'b0;
    abort          = 1'b0;
    cfg_pulse_size = $urandom;
    cfg_num_avg    = $urandom;
    cfg_num_runs   = RUN_W'($urandom);
    @(negedge clk);
    if (ok) begin
      check("start_clear", 64'(core_clear), 64'(1));
      check("start_busy", 64'(busy), 64'(1));
      check("start_psize", 64'(core_pulse_size), 64'(p));
      check("start_navg", 64'(core_num_avg), 64'(n));
      @(negedge clk);
      check("align_ready", 64'(s_tready), 64'(1));
      check("clear_once", 64'(core_clear), 64'(0));
    end else begin
      check("cfg_err", 64'(err_cfg), 64'(1));
      check("cfg_busy", 64'(busy), 64'(0));
      check("cfg_noclear", 64'(core_clear), 64'(0));
      @(negedge clk);
      check("cfg_err_once", 64'(err_cfg), 64'(0));
      check("cfg_idle", 64'(busy), 64'(0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run(input int unsigned exp_rc, input int unsigned n, input bit last);
    @(negedge clk);
    check("drain_ready", 64'(s_tready), 64'(0));
    check("drain_pcnt", 64'(pulse_count), 64'(n));
    check("drain_busy", 64'(busy), 64'(1));
    @(posedge clk);
    #1;
    avg_tvalid = 1'b1;
    avg_tready = 1'b1;
    avg_tlast  = 1'b0;
    @(posedge clk);
    #1;
    avg_tlast  = 1'b1;
    @(negedge clk);
    check("avg_nolast", 64'(run_count), 64'(exp_rc - 1));
    @(posedge clk);
    #1;
    avg_tvalid = 1'b0;
    avg_tready = 1'b0;
    avg_tlast  = 1'b0;
    @(negedge clk);
    check("run_count", 64'(run_count), 64'(exp_rc));
    check("done_pulse", 64'(done), 64'(last));
    if (last) begin
      @(negedge clk);
      check("done_once", 64'(done), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
    end else begin
      check("next_clear", 64'(core_clear), 64'(1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare_beats();
    check("beat_cnt", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check("beat", 64'(got_q[i]), 64'(exp_q[i]));
    end
    check("err_len_cnt", 64'(err_seen), 64'(exp_err));
    got_q.delete();
    exp_q.delete();
    err_seen = 0;
    exp_err  = 0;
  endtask

  initial begin
    int unsigned p;
    int unsigned n;
    int unsigned k;
    int unsigned clr0;
    reset_n = 1'b0; cfg_pulse_size = '0; cfg_num_avg = '0; cfg_num_runs = '0;
    start = 1'b0; abort = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    avg_tvalid = 1'b0; avg_tready = 1'b0; avg_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_psize", 64'(core_pulse_size), 64'(MAXP));
    check("rst_navg", 64'(core_num_avg), 64'(1));
    check("rst_outs", 64'({core_clear, done, err_cfg, err_len, s_tready, core_tvalid}), 64'(0));
    check("rst_cnts", 64'({run_count, pulse_count}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single run, pulse_size 4, num_avg 3.
    do_start(4, 3, 1, 1'b1, 1'b0);
    feed_run(4, 12, 0);
    finish_run(1, 3, 1'b1);
    compare_beats();

    // Same run under random core backpressure and source gaps.
    bp_en = 1'b1; gap_en = 1'b1;
    do_start(4, 3, 1, 1'b1, 1'b0);
    feed_run(4, 12, 0);
    finish_run(1, 3, 1'b1);
    compare_beats();

    // Config errors and the largest legal pulse size.
    bp_en = 1'b0; gap_en = 1'b0;
    clr0 = clear_seen;
    do_start(0, 1, 1, 1'b0, 1'b0);
    do_start(MAXP + 1, 1, 1, 1'b0, 1'b0);
    do_start(4, 0, 1, 1'b0, 1'b0);
    check("cfg_clear_cnt", 64'(clear_seen), 64'(clr0));
    do_start(MAXP, 1, 1, 1'b1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    check("align_abort_clear", 64'(core_clear), 64'(1));
    check("align_abort_ready", 64'(s_tready), 64'(0));
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("align_abort_idle", 64'(busy), 64'(0));
    @(posedge clk);
    #1;

    // Input tlast one beat early: framing holds, err_len flags mismatches.
    do_start(4, 1, 1, 1'b1, 1'b0);
    feed_run(4, 4, 2);
    finish_run(1, 1, 1'b1);
    compare_beats();

    // Single-sample pulses.
    do_start(1, 4, 1, 1'b1, 1'b0);
    feed_run(1, 4, 0);
    finish_run(1, 4, 1'b1);
    compare_beats();

    // Randomized two-run sets with tlast errors and backpressure.
    bp_en = 1'b1; gap_en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      p = $urandom_range(1, 6);
      n = $urandom_range(1, 4);
      do_start(p, n, 2, 1'b1, 1'b0);
      for (int r = 1; r <= 2; r++) begin
        feed_run(p, p * n, 1);
        finish_run(r, n, r == 2);
      end
      compare_beats();
    end

    // Continuous mode: three runs, then abort part-way through PASS.
    bp_en = 1'b0; gap_en = 1'b0;
    done_seen = 0;
    p = $urandom_range(2, 5);
    n = $urandom_range(1, 3);
    do_start(p, n, 0, 1'b1, 1'b0);
    for (int r = 1; r <= 3; r++) begin
      feed_run(p, p * n, 0);
      finish_run(r, n, 1'b0);
    end
    k = $urandom_range(1, p * n - 1);
    feed_run(p, k, 0);
    abort = 1'b1; s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = 1'b0;
    @(negedge clk);
    check("abort_clear", 64'(core_clear), 64'(1));
    check("abort_tvalid", 64'(core_tvalid), 64'(0));
    check("abort_tready", 64'(s_tready), 64'(0));
    @(posedge clk);
    #1;
    abort = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'(busy), 64'(0));
    check("abort_clear_end", 64'(core_clear), 64'(0));
    check("abort_runs", 64'(run_count), 64'(3));
    check("abort_pcnt", 64'(pulse_count), 64'(k / p));
    check("abort_no_done", 64'(done_seen), 64'(0));
    compare_beats();
    @(posedge clk);
    #1;

    // start wins over a simultaneous abort; then reset during DRAIN.
    bp_en = 1'b1;
    do_start(3, 2, 2, 1'b1, 1'b1);
    feed_run(3, 6, 0);
    finish_run(1, 2, 1'b0);
    feed_run(3, 6, 1);
    @(negedge clk);
    check("pre_rst_pcnt", 64'(pulse_count), 64'(2));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_psize", 64'(core_pulse_size), 64'(MAXP));
    check("mid_rst_navg", 64'(core_num_avg), 64'(1));
    check("mid_rst_outs", 64'({core_clear, done, err_cfg, err_len, s_tready, core_tvalid}), 64'(0));
    check("mid_rst_cnts", 64'({run_count, pulse_count}), 64'(0));
    compare_beats();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_avg_sequencer.md
# pulse_avg_sequencer

Run controller placed between the AXI wrapper's sample stream and `pulse_avg_core` in the Doppler tracker CE. It latches the averaging configuration at run start, clears the averager, aligns to a packet boundary, and gates exactly `num_avg` pulses of `pulse_size` samples into the core. It then waits for the averaged pulse to leave the core and repeats for a programmed number of runs. It reports run and pulse counts and flags length or configuration errors.

## Interface
- `MAX_PULSE_SIZE`, 8192: largest legal `cfg_pulse_size`.
- `RUN_W`, 16: width of run counters.
- `clk` in 1: CE clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_pulse_size` in 32: samples per pulse (setting register).
- `cfg_num_avg` in 32: pulses averaged per run.
- `cfg_num_runs` in RUN_W: runs per start; 0 means continuous.
- `start` in 1: one-cycle run request.
- `abort` in 1: one-cycle stop request.
- `s_tdata` in 32, `s_tlast` in 1, `s_tvalid` in 1, `s_tready` out 1: sample stream from the AXI wrapper.
- `core_tdata` out 32, `core_tlast` out 1, `core_tvalid` out 1, `core_tready` in 1: sample stream to `pulse_avg_core`.
- `core_clear` out 1: averager clear pulse.
- `core_pulse_size` out 32, `core_num_avg` out 32: latched config driven to the core.
- `avg_tvalid` in 1, `avg_tready` in 1, `avg_tlast` in 1: monitor taps on the core output handshake.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the final run completes.
- `err_cfg` out 1, `err_len` out 1: one-cycle error pulses.
- `run_count` out RUN_W: runs completed since the last start.
- `pulse_count` out 32: pulses passed in the current run.

## Operation
- States: IDLE, CLEAR, ALIGN, PASS, DRAIN, DONE.
- **IDLE:** `s_tready`=0. `start` is sampled only in IDLE.
  - If `cfg_pulse_size`=0, `cfg_pulse_size`>MAX_PULSE_SIZE, or `cfg_num_avg`=0: pulse `err_cfg` and stay in IDLE.
  - Otherwise latch the three cfg inputs into `core_pulse_size`, `core_num_avg` and the internal run limit. Zero `run_count`, then go to CLEAR.
- **CLEAR:** `core_clear`=1 for exactly one cycle. Zero `pulse_count` and the sample counter, then go to ALIGN.
- **ALIGN:** `s_tready`=1 and input beats are discarded (`core_tvalid`=0). After the handshake of a beat with `s_tlast`=1, go to PASS.
- **PASS:** combinational pass-through, zero latency.
  - `core_tvalid`=`s_tvalid`, `s_tready`=`core_tready`, `core_tdata`=`s_tdata`.
  - The sample counter increments on each core handshake.
  - `core_tlast`=1 when the sample counter equals `core_pulse_size`-1. The counter then wraps to 0 and `pulse_count` increments.
  - Input `s_tlast` is ignored for framing. If `s_tlast` disagrees with the generated `core_tlast` on a handshaked beat, pulse `err_len` one cycle after that beat.
  - When `pulse_count` reaches `core_num_avg` (on the last beat's handshake), go to DRAIN.
- **DRAIN:** `s_tready`=0, `core_tvalid`=0. On `avg_tvalid`&`avg_tready`&`avg_tlast`, increment `run_count`.
  - If run limit≠0 and the new `run_count` equals the limit, go to DONE.
  - Otherwise go to CLEAR (next run, no new ALIGN skipped: ALIGN repeats).
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **abort:** accepted in any state except IDLE. Next state is IDLE, `core_clear` pulses that same cycle, and `core_tvalid`/`s_tready` drop immediately. Counters hold their values. `done` is not pulsed.
- `abort` and `start` in the same cycle while in IDLE: `start` is processed and `abort` is ignored.
- `abort` in the cycle a DRAIN completion occurs: `abort` wins and `run_count` still increments.
- `run_count` saturates at all-ones in continuous mode.

## Timing
- Reset values (async on `reset_n` low):
  - state IDLE;
  - all counters 0;
  - `core_pulse_size`=MAX_PULSE_SIZE, `core_num_avg`=1;
  - `core_clear`, `done`, `err_cfg`, `err_len`, `busy`, `s_tready`, `core_tvalid` all 0.
- Reset mid-run returns to IDLE with no `done`. The core is cleared by its own reset.
- `start` to `core_clear`: 1 cycle. `core_clear` to first ALIGN `s_tready`: 1 cycle.
- All state registers, counters and pulse outputs are registered. Only the PASS/ALIGN stream signals are combinational from the inputs.
- `cfg_*` changes during a run have no effect until the next `start`.

## Test plan
- **Single run:** pulse_size=4, num_avg=3, num_runs=1, start, then feed a junk beat with tlast followed by 12 beats.
  - Junk beat is dropped.
  - 12 beats are passed, with `core_tlast` on beats 4, 8 and 12.
  - DRAIN is entered; an avg tlast handshake leads to `done`, `run_count`=1, then IDLE.
- **Backpressure:** in the single-run setup, toggle `core_tready` randomly.
  - No beat is lost or duplicated.
  - `s_tready` tracks `core_tready` exactly while in PASS.
- **Config errors:** start with pulse_size=0, then pulse_size=8193, then num_avg=0.
  - Each attempt gives an `err_cfg` pulse, `busy` stays 0, and `core_clear` never asserts.
- **Length mismatch:** pulse_size=4, input tlast on beat 3.
  - `err_len` pulses.
  - `core_tlast` still asserts on beat 4.
- **Continuous and abort:** num_runs=0, run 3 cycles, assert abort in PASS.
  - `run_count`=3.
  - `core_clear` asserts in the abort cycle.
  - Next cycle is IDLE; no `done`.
- **Reset mid-run:** drop `reset_n` during DRAIN.
  - All outputs immediately return to their reset values.
